// File: rtl/silent_stage_buffer.sv
// silent_stage_buffer
//
// Double-buffered staging register for the silencer output stage.
// Per-channel duty/phase words arrive serially into a shadow bank and are
// committed atomically to the parallel output arrays. The commit happens
// either immediately on DONE (SYNC_MODE=0) or at the next SYNC strobe
// (SYNC_MODE=1).
//
// Ports:
//   CLK            system clock, rising edge
//   RST            synchronous active-high reset
//   WR_EN          write one channel into the shadow bank
//   WR_ADDR        channel index; indices >= DEPTH are ignored
//   DUTY_IN        duty word for WR_ADDR
//   PHASE_IN       phase word for WR_ADDR
//   DONE           frame-complete request, starts a commit
//   SYNC           one-cycle period-boundary strobe
//   SYNC_MODE      0 = commit on DONE, 1 = commit on SYNC
//   CLR_FLAGS      clears both sticky error flags
//   DUTY_OUT       committed duty array
//   PHASE_OUT      committed phase array
//   BUSY           a commit is pending (waiting for SYNC)
//   UPDATED        one-cycle pulse in the cycle after each commit edge
//   FILL_COUNT     distinct channels written since the last commit
//   ERR_INCOMPLETE sticky: a commit happened with an incomplete frame
//   ERR_OVERRUN    sticky: a write or DONE was dropped while pending

module silent_stage_buffer #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_EN,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic [WIDTH-1:0] DUTY_IN,
    input  logic [WIDTH-1:0] PHASE_IN,
    input  logic             DONE,
    input  logic             SYNC,
    input  logic             SYNC_MODE,
    input  logic             CLR_FLAGS,
    output logic [WIDTH-1:0] DUTY_OUT  [0:DEPTH-1],
    output logic [WIDTH-1:0] PHASE_OUT [0:DEPTH-1],
    output logic             BUSY,
    output logic             UPDATED,
    output logic [CW-1:0]    FILL_COUNT,
    output logic             ERR_INCOMPLETE,
    output logic             ERR_OVERRUN
);

    typedef enum logic {
        LOAD    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] shadow_duty       [0:DEPTH-1];
    logic [WIDTH-1:0] shadow_phase      [0:DEPTH-1];
    logic [WIDTH-1:0] shadow_duty_next  [0:DEPTH-1];
    logic [WIDTH-1:0] shadow_phase_next [0:DEPTH-1];

    logic [DEPTH-1:0] mask;
    logic [DEPTH-1:0] mask_next;

    logic addr_ok;
    logic write_ok;
    logic new_channel;
    logic commit;
    logic overrun_event;
    logic incomplete_event;

    // The zero-extended compare stays correct even when DEPTH is a power of two.
    assign addr_ok  = ({1'b0, WR_ADDR} < (AW + 1)'(DEPTH));
    assign write_ok = WR_EN && addr_ok && (state == LOAD);

    // Writes are dropped in PENDING, so only a LOAD-state write can be new.
    assign new_channel = write_ok && !mask[WR_ADDR];

    assign commit = ((state == LOAD) && DONE && (!SYNC_MODE || SYNC)) ||
                    ((state == PENDING) && SYNC);

    assign overrun_event = (state == PENDING) && (WR_EN || DONE);

    // The mask seen by a commit includes a same-cycle forwarded write.
    assign mask_next        = write_ok ? (mask | (DEPTH'(1) << WR_ADDR)) : mask;
    assign incomplete_event = commit && (mask_next != {DEPTH{1'b1}});

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: SYNC_MODE only matters at the DONE in LOAD
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (DONE && SYNC_MODE && !SYNC) state_next = PENDING;
            PENDING: if (SYNC) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // FSM outputs
    always_comb begin
        BUSY = (state == PENDING);
    end

    // Shadow contents after this cycle's write; a commit copies this view,
    // which gives write forwarding for free.
    always_comb begin
        shadow_duty_next  = shadow_duty;
        shadow_phase_next = shadow_phase;
        if (write_ok) begin
            shadow_duty_next[WR_ADDR]  = DUTY_IN;
            shadow_phase_next[WR_ADDR] = PHASE_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow_duty  <= '{default: '0};
            shadow_phase <= '{default: '0};
            DUTY_OUT     <= '{default: '0};
            PHASE_OUT    <= '{default: '0};
        end else begin
            shadow_duty  <= shadow_duty_next;
            shadow_phase <= shadow_phase_next;
            if (commit) begin
                DUTY_OUT  <= shadow_duty_next;
                PHASE_OUT <= shadow_phase_next;
            end
        end
    end

    // Fill tracking: a commit starts a new frame, the shadow keeps its data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mask       <= '0;
            FILL_COUNT <= '0;
            UPDATED    <= 1'b0;
        end else begin
            UPDATED <= commit;
            if (commit) begin
                mask       <= '0;
                FILL_COUNT <= '0;
            end else begin
                mask <= mask_next;
                if (new_channel) FILL_COUNT <= FILL_COUNT + CW'(1);
            end
        end
    end

    // Sticky flags: a set event in the same cycle beats CLR_FLAGS.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR_INCOMPLETE <= 1'b0;
            ERR_OVERRUN    <= 1'b0;
        end else begin
            if (incomplete_event)  ERR_INCOMPLETE <= 1'b1;
            else if (CLR_FLAGS)    ERR_INCOMPLETE <= 1'b0;
            if (overrun_event)     ERR_OVERRUN <= 1'b1;
            else if (CLR_FLAGS)    ERR_OVERRUN <= 1'b0;
        end
    end

endmodule

// File: doc/silent_stage_buffer.md
# silent_stage_buffer

Parametrised double-buffered staging register for the silencer output stage. Per-channel duty/phase updates arrive serially, one channel per write, into a shadow bank. The shadow bank is committed atomically to the parallel output arrays, either immediately on DONE or deferred to the next SYNC period-boundary strobe. Fill tracking and sticky error flags let the controller detect partial or overrun frames. The block sits between the silencer filter and the PWM generators.

## Interface
- WIDTH, 13: bit width of each duty/phase word.
- DEPTH, 249: number of transducer channels.
- AW, $clog2(DEPTH): width of WR_ADDR (derived; do not override).
- CW, $clog2(DEPTH+1): width of FILL_COUNT (derived).

- Clocking: one clock; reset is synchronous and active-high.
- CLK  in  1  system clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- WR_EN  in  1  write one channel into the shadow bank this cycle.
- WR_ADDR  in  AW  channel index; values >= DEPTH are ignored.
- DUTY_IN  in  WIDTH  duty word for WR_ADDR.
- PHASE_IN  in  WIDTH  phase word for WR_ADDR.
- DONE  in  1  frame-complete request; starts a commit.
- SYNC  in  1  one-cycle period-boundary strobe.
- SYNC_MODE  in  1  0 = commit on DONE; 1 = commit on SYNC.
- CLR_FLAGS  in  1  clears ERR_INCOMPLETE and ERR_OVERRUN.
- DUTY_OUT[0:DEPTH-1]  out  WIDTH each  committed duty array.
- PHASE_OUT[0:DEPTH-1]  out  WIDTH each  committed phase array.
- BUSY  out  1  high while a commit is pending (PENDING state).
- UPDATED  out  1  one-cycle pulse in the cycle after each commit edge.
- FILL_COUNT  out  CW  distinct channels written since the last commit.
- ERR_INCOMPLETE  out  1  sticky: a commit occurred with FILL_COUNT < DEPTH.
- ERR_OVERRUN  out  1  sticky: a write or DONE was dropped while in PENDING.

## Operation
- State machine has two states, LOAD and PENDING. Reset enters LOAD.
- **Shadow bank and valid mask**
  - Shadow bank holds DEPTH duty/phase pairs.
  - A DEPTH-bit valid mask records which channels have been written since the last commit.
- **LOAD, write**
  - WR_EN with an in-range WR_ADDR writes the shadow entry and sets its mask bit.
  - FILL_COUNT increments only if the mask bit was previously 0; a rewrite does not count.
  - A write with WR_ADDR >= DEPTH has no effect.
- **LOAD, DONE**
  - SYNC_MODE is sampled here.
  - SYNC_MODE=0: commit at this edge.
  - SYNC_MODE=1 and SYNC=1 in the same cycle: commit at this edge.
  - SYNC_MODE=1 and SYNC=0: go to PENDING.
- **PENDING**
  - BUSY=1.
  - SYNC=1 causes a commit at that edge and a return to LOAD.
  - WR_EN or DONE in PENDING is dropped and sets ERR_OVERRUN.
  - SYNC_MODE changes in PENDING are ignored.
- **Commit**
  - For every channel i: DUTY_OUT[i]/PHASE_OUT[i] take the shadow entry i.
  - Write forwarding: if WR_EN is high with WR_ADDR==i in the commit cycle (LOAD only), that channel takes DUTY_IN/PHASE_IN instead, and the shadow is written too.
  - ERR_INCOMPLETE is set if the post-write mask is not all ones.
  - Mask and FILL_COUNT clear to 0.
  - UPDATED pulses in the next cycle.
  - The shadow bank retains its contents, so partial frames keep old values for unwritten channels.
- **Flags**
  - CLR_FLAGS clears both error flags.
  - A same-cycle set event wins over CLR_FLAGS.
- Reset mid-PENDING discards the pending commit.

## Timing
- **Reset values:** all DUTY_OUT/PHASE_OUT 0; shadow 0; mask 0; FILL_COUNT 0; BUSY 0; UPDATED 0; both error flags 0; state LOAD.
- **Immediate mode:** DONE sampled at edge k, outputs valid from cycle k+1, UPDATED high during cycle k+1.
- **Sync mode:** DONE at edge k with SYNC first high at edge m>k.
  - BUSY is high in cycles k+1..m.
  - Outputs update at edge m; UPDATED is high in cycle m+1.
- Back-to-back commits are allowed; UPDATED may then stay high on consecutive cycles.
- FILL_COUNT reflects writes one cycle after the write edge.
- Outputs never change except at a commit edge or at reset.

## Test plan
- **Reset:** assert RST for 2 cycles with random inputs -> all outputs 0, BUSY=0, FILL_COUNT=0.
- **Full frame, immediate mode:** SYNC_MODE=0; write channels 0..248 with duty=i, phase=i+100; DONE with a same-cycle write of ch 248 (duty 0x1FFF) -> outputs update next cycle, DUTY_OUT[248]=0x1FFF, UPDATED single pulse, ERR_INCOMPLETE=0, FILL_COUNT=0.
- **Sync mode deferral:** SYNC_MODE=1; write ch 5 = 777; DONE; SYNC 10 cycles later.
  - BUSY high for 10 cycles; DUTY_OUT[5] still the old value.
  - Updates at the SYNC edge; ERR_INCOMPLETE=1.
  - Other channels keep their previous values.
- **Overrun:** in PENDING, issue WR_EN ch 3 = 55 and a second DONE -> ERR_OVERRUN=1, shadow[3] unchanged after commit; CLR_FLAGS clears ERR_OVERRUN.
- **FILL_COUNT rules:** write ch 7 three times plus ch 249 (out of range) -> FILL_COUNT=1; DONE together with SYNC, SYNC_MODE=1 -> immediate commit, no BUSY.
- **Reset mid-PENDING:** DONE in sync mode, RST before SYNC -> no UPDATED, outputs 0, BUSY=0.
